// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation encoding, divider FSM states and
// divide-by-zero result constant.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_MOD  = 4'd14,
        ALU_MODU = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Divide by zero yields an all-ones quotient; the remainder is the dividend.
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic is_div_op(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_MOD) || (op == ALU_MODU);
    endfunction

    function automatic logic is_signed_div_op(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/iter_div.sv
// Restoring divider: one quotient bit per cycle on operand magnitudes,
// signs re-applied on the outputs.
module iter_div
    import cpu_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CNT_W = $clog2(DIV_ITERS) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dsr_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             div_zero_q;
    logic             neg1;
    logic             neg2;
    logic [32:0]      r_shift;
    logic [32:0]      trial;

    assign neg1 = signed_op & dividend[31];
    assign neg2 = signed_op & divisor[31];

    // Partial remainder is always below the divisor, so bit 32 of the trial
    // subtraction is a reliable "did not fit" flag.
    assign r_shift = {rem_q, quo_q[31]};
    assign trial   = r_shift - {1'b0, dsr_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (start) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            quo_q      <= neg1 ? -dividend : dividend;
            rem_q      <= '0;
            dsr_q      <= neg2 ? -divisor : divisor;
            q_neg_q    <= neg1 ^ neg2;
            r_neg_q    <= neg1;
            div_zero_q <= (divisor == 32'd0);
        end else if (busy_q) begin
            rem_q <= trial[32] ? r_shift[31:0] : trial[31:0];
            quo_q <= {quo_q[30:0], ~trial[32]};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == LAST_ITER);
    assign quotient  = div_zero_q ? DIV_ZERO_QUOTIENT : (q_neg_q ? -quo_q : quo_q);
    assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Pipeline EXE stage: ALU, iterative divide sequencing and data-SRAM request.
// Handshake: a stage holds an instruction while valid; it passes it on the
// edge where its ready_go and the downstream allowin are both high.
module exe_stage
    import cpu_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds2es_valid,
    output logic        es_allowin,
    input  logic [31:0] ds_pc,
    input  alu_op_t     ds_alu_op,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [31:0] ds_rkd_value,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    input  logic        ds_res_from_mem,
    input  logic        ds_mem_we,
    input  logic        ms_allowin,
    output logic        es2ms_valid,
    output logic        es_valid,
    output logic [31:0] es_pc,
    output logic [31:0] alu_result,
    output logic        exe_res_from_mem,
    output logic [4:0]  exe_dest,
    output logic        exe_gr_we,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output div_state_t  div_state
);
    alu_op_t     op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] rkd_q;
    logic        mem_we_q;
    logic        es_ready_go;
    logic        is_div;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    div_state_t  state_q;
    div_state_t  state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds2es_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_pc            <= '0;
            op_q             <= ALU_ADD;
            src1_q           <= '0;
            src2_q           <= '0;
            rkd_q            <= '0;
            exe_dest         <= '0;
            exe_gr_we        <= 1'b0;
            exe_res_from_mem <= 1'b0;
            mem_we_q         <= 1'b0;
        end else if (ds2es_valid && es_allowin) begin
            es_pc            <= ds_pc;
            op_q             <= ds_alu_op;
            src1_q           <= ds_src1;
            src2_q           <= ds_src2;
            rkd_q            <= ds_rkd_value;
            exe_dest         <= ds_dest;
            exe_gr_we        <= ds_gr_we;
            exe_res_from_mem <= ds_res_from_mem;
            mem_we_q         <= ds_mem_we;
        end
    end

    assign is_div      = is_div_op(op_q);
    assign es_ready_go = is_div ? (state_q == DIV_DONE) : 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;
    assign div_start   = es_valid & is_div & (state_q == DIV_IDLE) & ~div_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (div_start)                  state_d = DIV_BUSY;
            DIV_BUSY: if (div_done)                   state_d = DIV_DONE;
            DIV_DONE: if (es2ms_valid && ms_allowin)  state_d = DIV_IDLE;
            default:                                  state_d = DIV_IDLE;
        endcase
    end

    assign div_state = state_q;

    iter_div #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .signed_op (is_signed_div_op(op_q)),
        .dividend  (src1_q),
        .divisor   (src2_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        alu_result = '0;
        case (op_q)
            ALU_ADD:  alu_result = src1_q + src2_q;
            ALU_SUB:  alu_result = src1_q - src2_q;
            ALU_SLT:  alu_result = {31'd0, $signed(src1_q) < $signed(src2_q)};
            ALU_SLTU: alu_result = {31'd0, src1_q < src2_q};
            ALU_AND:  alu_result = src1_q & src2_q;
            ALU_OR:   alu_result = src1_q | src2_q;
            ALU_NOR:  alu_result = ~(src1_q | src2_q);
            ALU_XOR:  alu_result = src1_q ^ src2_q;
            ALU_SLL:  alu_result = src1_q << src2_q[4:0];
            ALU_SRL:  alu_result = src1_q >> src2_q[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(src1_q) >>> src2_q[4:0]);
            ALU_LUI:  alu_result = src2_q;
            ALU_DIV,
            ALU_DIVU: alu_result = div_quo;
            ALU_MOD,
            ALU_MODU: alu_result = div_rem;
            default:  alu_result = '0;
        endcase
    end

    assign data_sram_en    = es_valid & es_ready_go & ms_allowin & (exe_res_from_mem | mem_we_q);
    assign data_sram_we    = {4{data_sram_en & mem_we_q}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU vector table plus divide, store-stall,
// reset-abort and back-to-back sequences.
module tb_exe_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds2es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    alu_op_t     ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [31:0] ds_rkd_value;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ds_res_from_mem;
    logic        ds_mem_we;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic        es_valid;
    logic [31:0] es_pc;
    logic [31:0] alu_result;
    logic        exe_res_from_mem;
    logic [4:0]  exe_dest;
    logic        exe_gr_we;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    div_state_t  div_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    exe_stage #(.DIV_ITERS(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ds2es_valid      (ds2es_valid),
        .es_allowin       (es_allowin),
        .ds_pc            (ds_pc),
        .ds_alu_op        (ds_alu_op),
        .ds_src1          (ds_src1),
        .ds_src2          (ds_src2),
        .ds_rkd_value     (ds_rkd_value),
        .ds_dest          (ds_dest),
        .ds_gr_we         (ds_gr_we),
        .ds_res_from_mem  (ds_res_from_mem),
        .ds_mem_we        (ds_mem_we),
        .ms_allowin       (ms_allowin),
        .es2ms_valid      (es2ms_valid),
        .es_valid         (es_valid),
        .es_pc            (es_pc),
        .alu_result       (alu_result),
        .exe_res_from_mem (exe_res_from_mem),
        .exe_dest         (exe_dest),
        .exe_gr_we        (exe_gr_we),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .div_state        (div_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_instr(input alu_op_t op, input logic [31:0] pc, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] rkd,
                             input logic rfm, input logic mwe);
        ds2es_valid     = 1'b1;
        ds_pc           = pc;
        ds_alu_op       = op;
        ds_src1         = a;
        ds_src2         = b;
        ds_rkd_value    = rkd;
        ds_dest         = 5'd3;
        ds_gr_we        = ~mwe;
        ds_res_from_mem = rfm;
        ds_mem_we       = mwe;
    endtask

    // Returns at the negedge of the DONE cycle, leaving the result on the outputs.
    task automatic run_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name);
        int k;
        logic allow_seen;
        @(negedge clk);
        set_instr(op, 32'h0000_0100, a, b, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        ds2es_valid = 1'b0;
        k = 0;
        allow_seen = 1'b0;
        while (!es2ms_valid && k < 40) begin
            if (es_allowin) allow_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'd33);
        check({name, "_allowin_low"}, {31'd0, allow_seen}, 32'd0);
        check(name, alu_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"add_ovf", ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{"sub",     ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vecs[2]  = '{"slt",     ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{"sltu",    ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[4]  = '{"and",     ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[5]  = '{"or",      ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[6]  = '{"nor",     ALU_NOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000};
        vecs[7]  = '{"xor",     ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[8]  = '{"sll",     ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[9]  = '{"srl",     ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[10] = '{"sra",     ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[11] = '{"lui",     ALU_LUI,  32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000};

        reset       = 1'b1;
        ms_allowin  = 1'b1;
        set_instr(ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        ds2es_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_es_valid",    {31'd0, es_valid},     32'd0);
        check("rst_es2ms_valid", {31'd0, es2ms_valid},  32'd0);
        check("rst_allowin",     {31'd0, es_allowin},   32'd1);
        check("rst_sram_en",     {31'd0, data_sram_en}, 32'd0);
        check("rst_sram_we",     {28'd0, data_sram_we}, 32'd0);
        check("rst_pc",          es_pc,                 32'd0);
        check("rst_result",      alu_result,            32'd0);
        check("rst_state",       32'(div_state),        32'(DIV_IDLE));
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_instr(vecs[i].op, 32'h1000 + 32'(i * 4), vecs[i].a, vecs[i].b, 32'd0, 1'b0, 1'b0);
            @(negedge clk);
            ds2es_valid = 1'b0;
            check(vecs[i].name, alu_result, vecs[i].exp);
            check({vecs[i].name, "_valid"}, {31'd0, es2ms_valid}, 32'd1);
            check({vecs[i].name, "_pc"}, es_pc, 32'h1000 + 32'(i * 4));
            check({vecs[i].name, "_sram_en"}, {31'd0, data_sram_en}, 32'd0);
        end

        run_div(ALU_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_m7_2");
        run_div(ALU_MOD,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "mod_m7_2");
        run_div(ALU_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, "divu_5_0");
        run_div(ALU_MODU, 32'd5,         32'd0,        32'h0000_0005, "modu_5_0");
        run_div(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_min_m1");
        run_div(ALU_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mod_min_m1");
        run_div(ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, "divu_big");

        // Store held by a stalled MEM for three cycles.
        @(negedge clk);
        ms_allowin = 1'b0;
        set_instr(ALU_ADD, 32'h300, 32'h0000_1000, 32'h0000_0024, 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(negedge clk);
        ds2es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_stall_en",      {31'd0, data_sram_en}, 32'd0);
            check("st_stall_valid",   {31'd0, es_valid},     32'd1);
            check("st_stall_allowin", {31'd0, es_allowin},   32'd0);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        check("st_en",    {31'd0, data_sram_en}, 32'd1);
        check("st_we",    {28'd0, data_sram_we}, 32'hF);
        check("st_addr",  data_sram_addr,        32'h0000_1024);
        check("st_wdata", data_sram_wdata,       32'hDEAD_BEEF);
        @(negedge clk);
        check("st_once_en", {31'd0, data_sram_en}, 32'd0);
        check("st_drained", {31'd0, es_valid},     32'd0);

        // Reset in the tenth BUSY cycle abandons the divide.
        @(negedge clk);
        set_instr(ALU_DIV, 32'h400, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        ds2es_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rb_busy", 32'(div_state), 32'(DIV_BUSY));
        reset = 1'b1;
        #1;
        check("rb_es_valid", {31'd0, es_valid},    32'd0);
        check("rb_allowin",  {31'd0, es_allowin},  32'd1);
        check("rb_es2ms",    {31'd0, es2ms_valid}, 32'd0);
        check("rb_state",    32'(div_state),       32'(DIV_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_instr(ALU_ADD, 32'h500, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        ds2es_valid = 1'b0;
        check("rb_add",       alu_result,           32'd7);
        check("rb_add_valid", {31'd0, es2ms_valid}, 32'd1);
        check("rb_add_pc",    es_pc,                32'h500);

        // Back-to-back divide then ADD taken on the DONE handoff edge.
        run_div(ALU_DIV, 32'd100, 32'd7, 32'd14, "b2b_div");
        set_instr(ALU_ADD, 32'h600, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        ds2es_valid = 1'b0;
        check("b2b_add",       alu_result,           32'd3);
        check("b2b_add_valid", {31'd0, es2ms_valid}, 32'd1);
        check("b2b_add_pc",    es_pc,                32'h600);
        check("b2b_state",     32'(div_state),       32'(DIV_IDLE));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL take parameter DIV_ITERS, default 32, giving divider iterations; only the value 32 is supported.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ds2es_valid  input  1  decode holds a valid instruction for EXE.
REQ-005 SHALL have es_allowin  output  1  EXE accepts an instruction this cycle.
REQ-006 SHALL have ds_pc  input  32  decode PC.
REQ-007 SHALL have ds_alu_op  input  4  encoded operation (package enum).
REQ-008 SHALL have ds_src1, ds_src2  input  32 each  operands.
REQ-009 SHALL have ds_rkd_value  input  32  store data.
REQ-010 SHALL have ds_dest  input  5, ds_gr_we  input  1, ds_res_from_mem  input  1, ds_mem_we  input  1  writeback and memory controls.
REQ-011 SHALL have ms_allowin  input  1  MEM can accept.
REQ-012 SHALL have es2ms_valid  output  1  result valid toward MEM.
REQ-013 SHALL have es_valid  output  1, es_pc  output  32  stage occupancy and PC.
REQ-014 SHALL have alu_result  output  32, exe_res_from_mem  output  1, exe_dest  output  5, exe_gr_we  output  1  MEM payload.
REQ-015 SHALL have data_sram_en  output  1, data_sram_we  output  4, data_sram_addr  output  32, data_sram_wdata  output  32  data-SRAM request.

Function
REQ-016 SHALL implement es_allowin = ~es_valid | (es_ready_go & ms_allowin), and es2ms_valid = es_valid & es_ready_go.
REQ-017 SHALL load es_valid from ds2es_valid whenever es_allowin=1, and capture all ds_* payload only when ds2es_valid & es_allowin.
REQ-018 SHALL support the ops ADD, SUB, SLT, SLTU, AND, OR, NOR, XOR, SLL, SRL, SRA, LUI (src2 passthrough), DIV, DIVU, MOD, MODU; the non-divide ops are combinational with es_ready_go=1.
REQ-019 SHALL use only src2[4:0] as the shift amount, and SLT/SLTU SHALL return 0 or 1 zero-extended.
REQ-020 SHALL run divide ops through a restoring divider FSM IDLE->BUSY->DONE->IDLE with es_ready_go = (state==DONE) for divide ops.
REQ-021 IDLE->BUSY SHALL happen when es_valid & divide op & state==IDLE, loading operand magnitudes and signs and clearing the iteration counter.
REQ-022 BUSY SHALL produce one quotient bit per cycle and go to DONE after exactly 32 cycles.
REQ-023 DONE SHALL hold the result until es2ms_valid & ms_allowin, then go to IDLE in the same edge.
REQ-024 Latency: with ms_allowin=1, a divide SHALL be in EXE for 34 cycles (entry, 32 BUSY, DONE); a non-divide SHALL take 1 cycle.
REQ-025 Signed results: quotient sign = sign1 XOR sign2, remainder sign = sign1; -2^31 / -1 SHALL give quotient 0x80000000 and remainder 0.
REQ-026 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = src1, with no exception.
REQ-027 data_sram_en SHALL = es_valid & es_ready_go & ms_allowin & (res_from_mem | mem_we).
REQ-028 data_sram_we SHALL = {4{data_sram_en & mem_we}}, with data_sram_addr = alu_result (ADD of base and offset) and data_sram_wdata = rkd_value.
REQ-029 A stalled MEM (ms_allowin=0) SHALL hold all EXE state and the DONE result, and SHALL issue no SRAM request.

Reset
REQ-030 While reset is asserted: es_valid=0, divider state=IDLE, counter=0, all payload registers 0; therefore es2ms_valid=0, data_sram_en=0, data_sram_we=0, es_allowin=1.
REQ-031 Reset during BUSY SHALL abandon the divide immediately, and the first post-reset instruction SHALL start from IDLE.

Structure
REQ-032 SHALL place the alu_op enum, the divide-op predicate and the divide-by-zero constants in shared package cpu_pkg.
REQ-033 SHALL place the divider in sub-module iter_div (start, signed, dividend, divisor -> busy, done, quotient, remainder), with FSM and ALU muxing in exe_stage.

Verification
REQ-034 SHALL check ADD 0x7FFFFFFF+1 -> alu_result 0x80000000, with es2ms_valid the cycle after capture.
REQ-035 SHALL check DIV -7/2 -> quotient 0xFFFFFFFD; MOD -> 0xFFFFFFFF; es2ms_valid asserted exactly 33 cycles after entry.
REQ-036 SHALL check DIVU 5/0 -> 0xFFFFFFFF and MODU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-037 SHALL check a store held while ms_allowin=0 for 3 cycles -> data_sram_en=0 for those cycles, then one cycle with we=4'hF and the correct addr/wdata.
REQ-038 SHALL check reset asserted at BUSY cycle 10 -> es_valid=0 immediately, and a following ADD completes in 1 cycle.
REQ-039 SHALL check back-to-back DIV then ADD with ms_allowin=1 -> es_allowin=0 throughout the divide, and the ADD is accepted on the DONE handoff edge.
